// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache constants, victim-queue FSM states and line geometry helper
package cache_pkg;

    typedef enum logic [1:0] {
        VQ_IDLE = 2'd0,
        VQ_AW   = 2'd1,
        VQ_W    = 2'd2,
        VQ_B    = 2'd3
    } vq_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

    // log2 of the number of 32-bit words in a line
    function automatic int offset_log(input int line_size);
        return $clog2(line_size / 4);
    endfunction

endpackage

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - circular buffer of {tag, data} with per-entry valid bits exposed for lookup
module line_fifo
    import cache_pkg::*;
#(
    parameter int TAG_W  = 28,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [TAG_W-1:0]              i_tag,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [TAG_W-1:0]              o_head_tag,
    output logic [DATA_W-1:0]             o_head_data,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][TAG_W-1:0]   o_tags
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]              r_head;
    logic [PTR_W-1:0]              r_tail;
    logic [PTR_W:0]                r_count;
    logic [DEPTH-1:0]              r_valid;
    logic [DEPTH-1:0][TAG_W-1:0]   r_tags;
    logic [DATA_W-1:0]             r_data [DEPTH];
    logic                          w_push_ok;
    logic                          w_pop_ok;

    assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_push_ok   = i_push && !o_full;
    assign w_pop_ok    = i_pop && (r_count != '0);
    assign o_count     = r_count;
    assign o_head_tag  = r_tags[r_head];
    assign o_head_data = r_data[r_head];
    assign o_valid     = r_valid;
    assign o_tags      = r_tags;

    // head==tail only when full or empty, so push and pop never touch the same valid bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop_ok) begin
                r_head          <= r_head + PTR_W'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (w_push_ok) begin
                r_tail          <= r_tail + PTR_W'(1);
                r_valid[r_tail] <= 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_tags[r_tail] <= i_tag;
            r_data[r_tail] <= i_data;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(i_push && o_full))
                else $warning("line_fifo: push while full dropped");
        end
    end

endmodule

// File: rtl/victim_write_queue.sv
// rtl/victim_write_queue.sv - dirty-victim write-back queue draining one AXI burst per line
module victim_write_queue
    import cache_pkg::*;
#(
    parameter int LINE_SIZE = 16,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_en,
    input  logic [31:0]            push_addr,
    input  logic [LINE_SIZE*8-1:0] push_data,
    output logic                   full,
    output logic                   empty,
    input  logic [31:0]            query_addr,
    output logic                   query_hit,
    output logic [31:0]            axi_awaddr,
    output logic [3:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [31:0]            axi_wdata,
    output logic [3:0]             axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    input  logic                   axi_bvalid,
    output logic                   axi_bready
);

    localparam int OFFSET_LOG = offset_log(LINE_SIZE);
    localparam int BEATS      = LINE_SIZE / 4;
    localparam int TAG_W      = 30 - OFFSET_LOG;
    localparam int BEAT_W     = (OFFSET_LOG > 0) ? OFFSET_LOG : 1;
    localparam int DATA_W     = LINE_SIZE * 8;

    vq_state_e                   r_state;
    vq_state_e                   w_state_nxt;
    logic [BEAT_W-1:0]           r_beat;
    logic [BEAT_W-1:0]           w_beat_nxt;
    logic                        w_pop;
    logic                        w_last_beat;
    logic                        w_full;
    logic [$clog2(DEPTH):0]      w_count;
    logic [TAG_W-1:0]            w_head_tag;
    logic [DATA_W-1:0]           w_head_data;
    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][TAG_W-1:0] w_tags;
    logic                        w_hit;

    line_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (push_en),
        .i_tag       (push_addr[31:2+OFFSET_LOG]),
        .i_data      (push_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_count     (w_count),
        .o_head_tag  (w_head_tag),
        .o_head_data (w_head_data),
        .o_valid     (w_valid),
        .o_tags      (w_tags)
    );

    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= VQ_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pop       = 1'b0;
        case (r_state)
            VQ_IDLE: if (w_count != '0) w_state_nxt = VQ_AW;
            VQ_AW: begin
                if (axi_awready) begin
                    w_state_nxt = VQ_W;
                    w_beat_nxt  = '0;
                end
            end
            VQ_W: begin
                if (axi_wready) begin
                    w_beat_nxt = w_last_beat ? '0 : r_beat + BEAT_W'(1);
                    if (w_last_beat) w_state_nxt = VQ_B;
                end
            end
            VQ_B: begin
                if (axi_bvalid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = VQ_IDLE;
                end
            end
            default: w_state_nxt = VQ_IDLE;
        endcase
    end

    // head entry stays valid through its burst, so in-flight lines still block refills
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_tags[i] == query_addr[31:2+OFFSET_LOG])) w_hit = 1'b1;
        end
    end

    assign full        = w_full;
    assign empty       = (w_count == '0) && (r_state == VQ_IDLE);
    assign query_hit   = w_hit;
    assign axi_awaddr  = {w_head_tag, (OFFSET_LOG+2)'(0)};
    assign axi_awlen   = 4'(BEATS - 1);
    assign axi_awsize  = AXI_SIZE_4B;
    assign axi_awvalid = (r_state == VQ_AW);
    assign axi_wdata   = w_head_data[32*r_beat +: 32];
    assign axi_wstrb   = AXI_WSTRB_FULL;
    assign axi_wlast   = (r_state == VQ_W) && w_last_beat;
    assign axi_wvalid  = (r_state == VQ_W);
    assign axi_bready  = (r_state == VQ_B);

endmodule

// File: doc/victim_write_queue.md
Name: victim_write_queue

Overview:
- Write-back queue that sits directly downstream of the data cache.
- On a miss that evicts a dirty line, the cache pushes the victim line (line address plus full line data) into this queue in one cycle.
- The queue drains each entry in order as one AXI write burst (AW, then W beats, then B).
- It exposes an address-match query so the cache can hold a refill read while the same line is still pending write-back.

Parameters:
- LINE_SIZE, 16, cache line size in bytes; must be a power of two and at least 4.
- DEPTH, 2, number of queued victim lines; must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- push_en  in  1  enqueue the victim line this cycle
- push_addr  in  32  victim line physical address; bits [OFFSET_LOG+1:0] are ignored and forced to zero
- push_data  in  LINE_SIZE*8  victim line data; word k is [32k+31:32k]
- full  out  1  count==DEPTH
- empty  out  1  count==0 and FSM in IDLE
- query_addr  in  32  physical address to check against queued lines
- query_hit  out  1  some valid entry's line address equals query_addr's line address
- axi_awaddr  out  32  burst address
- axi_awlen  out  4  burst length, LINE_SIZE/4-1
- axi_awsize  out  3  3'b010
- axi_awvalid  out  1  AW valid
- axi_awready  in  1  AW ready
- axi_wdata  out  32  write beat data
- axi_wstrb  out  4  4'hF
- axi_wlast  out  1  last beat
- axi_wvalid  out  1  W valid
- axi_wready  in  1  W ready
- axi_bvalid  in  1  write response valid
- axi_bready  out  1  write response ready

Behaviour:
- Derived constants: OFFSET_LOG = log2(LINE_SIZE/4); BEATS = LINE_SIZE/4.
- Reset (rst=0, asynchronous):
  - Queue pointers, count and beat counter are cleared; FSM goes to IDLE.
  - All valid bits are cleared.
  - awvalid, wvalid, wlast and bready are 0; full=0, empty=1, query_hit=0.
  - Any in-flight AXI transaction is abandoned; the interconnect shares this reset.
- Storage:
  - Circular buffer of {line_addr[31:2+OFFSET_LOG], data}, with head and tail pointers and a count of width log2(DEPTH)+1.
  - Push is accepted iff push_en & (count<DEPTH).
  - A push while full is dropped with no state change; a simulation assertion fires.
- FSM states: IDLE, AW, W, B.
  - IDLE: if count!=0, go to AW next cycle. Minimum latency from push to awvalid is 2 cycles.
  - AW:
    - awvalid=1, awaddr={head line_addr, zeros}.
    - Hold awvalid and awaddr stable until awready.
    - On awready: go to W, beat=0.
  - W:
    - wvalid=1, wdata = head word[beat].
    - wlast = (beat==BEATS-1).
    - On wready: beat+1 (modulo BEATS).
    - On wready & wlast: go to B.
    - wdata and wlast stay stable while wvalid & ~wready.
    - No W beat is driven before AW is accepted.
  - B: bready=1. On bvalid, pop the head (head+1 with wrap, count-1) and go to IDLE. bresp is not checked.
- Only one burst is outstanding at a time; entries drain in push order.
- Simultaneous push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - Push is judged against the registered count, so a push while full is still rejected even on the pop cycle.
- query_hit:
  - Combinational.
  - Covers every valid entry, including the head entry while its burst is in flight, until the pop cycle completes.
  - A push in the same cycle is not visible until the next cycle.
- Pointer wrap: head and tail wrap at DEPTH. count distinguishes full from empty.
- awlen, awsize and wstrb are constants.
- Outputs are decoded from registered state only; no combinational path from AXI ready inputs to valid outputs.

Decomposition:
- Shared package (cache_pkg):
  - OFFSET_LOG function of LINE_SIZE.
  - Victim-queue FSM state encodings, 2 bits.
  - AXI constants AXI_SIZE_4B=3'b010 and AXI_WSTRB_FULL=4'hF.
- Sub-module line_fifo:
  - Parameterised storage of {tag, data} with push/pop, full/count and a per-entry valid vector plus address array for the query compare.
  - The FSM and AXI logic stay in victim_write_queue.

Test Plan:
1. Reset mid-burst: push a line, hold wready=0 in W, drop rst -> awvalid=wvalid=bready=0, empty=1, query_hit=0 immediately; after release, no AXI activity.
2. Single line, LINE_SIZE=16, ready always high: push_addr=0x1234_567C, data words 0x11,0x22,0x33,0x44 -> awaddr=0x1234_5670, awlen=3, awsize=2; wdata 0x11,0x22,0x33,0x44 with wlast only on the 4th beat; bready until bvalid; then empty=1.
3. Backpressure: awready delayed 3 cycles, wready toggling 1/0 -> awaddr stable throughout, wdata never advances on wready=0, exactly 4 handshaked beats.
4. Fill and overflow, DEPTH=2, bvalid held low: push A, B, then C -> full=1 after B, C dropped; release bvalid -> bursts for A then B only.
5. Pop and push collide: full, then push D in the B-handshake cycle of A -> D rejected; push D the next cycle -> accepted; order B then D.
6. Query: push line 0x8000_0040 -> query_addr=0x8000_004C gives hit=1 during AW, W and B, and 0 the cycle after bvalid; query_addr=0x8000_0050 gives 0 throughout.
